memory_writer: RTL and testbench
================================

MEMORY_WRITER -- requirements
Module: memory_writer

Interface
REQ-001 Parameter W, default 16: data word width in bits; SHALL match the downstream memory width.
REQ-002 Parameter D, default 256: memory depth in words; A = $clog2(D) is the address width.
REQ-003 clk  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 cmd  input  2A+1  command {base[A-1:0], count[A:0]}; cmd_valid input 1, cmd_ready output 1.
REQ-006 data  input  W  word stream to store; data_valid input 1, data_ready output 1.
REQ-007 waddr  output  A  write address to the memory; waddr_valid output 1, waddr_ready input 1.
REQ-008 wdata  output  W  write data to the memory; wdata_valid output 1, wdata_ready input 1.
REQ-009 done  output  1  single-cycle pulse marking command completion.

Function
REQ-010 A transfer on any stream SHALL occur on a rising edge where its valid and ready are both high.
REQ-011 A valid SHALL NOT drop, and its payload SHALL NOT change, until that stream's transfer occurs.
REQ-012 The FSM SHALL have three states:
- IDLE: cmd_ready=1, data_ready=0.
- RUN: cmd_ready=0.
- DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-013 IDLE with a cmd transfer and count>0 -> RUN; latch addr=base and remaining=count.
REQ-014 IDLE with a cmd transfer and count==0 -> DONE; no waddr or wdata is issued.
REQ-015 In RUN, data_ready SHALL be high when all of the following hold: remaining>0, (!waddr_valid || waddr_ready), and (!wdata_valid || wdata_ready).
REQ-016 On a data transfer, the block SHALL on the next cycle:
- assert waddr_valid and wdata_valid together;
- present waddr=addr and wdata=data;
- set addr to (addr+1) mod D and decrement remaining.
REQ-017 waddr and wdata SHALL be accepted independently; each valid SHALL clear on its own transfer, in any order or in the same cycle.
REQ-018 Sustained throughput SHALL be one word per cycle when waddr_ready, wdata_ready and data_valid are held high; latency from data transfer to valid SHALL be 1 cycle.
REQ-019 Address SHALL wrap from D-1 to 0 with no error; count==D SHALL write every location exactly once.
REQ-020 RUN -> DONE on the cycle where remaining==0 and both waddr_valid and wdata_valid are low (or both are clearing); done SHALL be high on the following cycle.
REQ-021 cmd_valid during RUN or DONE SHALL be ignored and held off (cmd_ready=0).
REQ-022 Extra data beyond count SHALL NOT be accepted (data_ready=0).

Reset
REQ-023 While rst is high the block SHALL hold the following on the next edge and stay there:
- state=IDLE;
- cmd_ready=1 (after reset), data_ready=0;
- waddr_valid=0, wdata_valid=0, done=0;
- addr=0, remaining=0.
REQ-024 Reset mid-RUN SHALL abandon the command and drop any pending valids; no done pulse SHALL be emitted.
REQ-025 waddr and wdata payload registers need not be reset.

Structure
REQ-026 Shared package memory_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the helper that packs the cmd fields.
REQ-027 No sub-module SHALL be used; the block SHALL be a flat FSM with addr, remaining, and output registers.

Verification
REQ-028 Full sweep:
- stimulus: cmd {base=0, count=256}; 256 random words; both readies held high;
- response: waddr 0..255 in order, wdata equal to input; done exactly once; cycle count 258±1; readback through memory matches.
REQ-029 Wrap:
- stimulus: cmd {base=250, count=10};
- response: waddr sequence 250..255, then 0..3; done after the 10th pair.
REQ-030 Skewed readies:
- stimulus: waddr_ready random 50%, wdata_ready random 30%, count=64;
- response: no lost or duplicated pairs; each pair's waddr and wdata correspond; data_ready never high while a valid is pending and its ready is low.
REQ-031 Zero count:
- stimulus: cmd {base=5, count=0};
- response: no waddr or wdata valid; done high 1 cycle after the cmd transfer; cmd_ready high the cycle after that.
REQ-032 Reset mid-run:
- stimulus: rst asserted after 3 of 8 words, then released; new cmd {base=100, count=2};
- response: all valids low the cycle after rst; no done pulse; the second command writes 100 and 101, then done.
REQ-033 Back-pressure on cmd:
- stimulus: a second cmd_valid held during RUN;
- response: cmd_ready stays low until the cycle after done; the second command is then accepted.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory writer: FSM state encoding and
// command packing.
package memory_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Packs {base, count} for an address width of aw bits (count is aw+1 bits).
    function automatic logic [63:0] pack_cmd(int unsigned aw, logic [31:0] base,
                                             logic [31:0] count);
        logic [63:0] cnt_mask;
        cnt_mask = (64'd1 << (aw + 1)) - 64'd1;
        return ({32'd0, base} << (aw + 1)) | ({32'd0, count} & cnt_mask);
    endfunction

endpackage

// File: rtl/memory_writer.sv
// Streams a counted run of data words into consecutive memory addresses,
// issuing address and data on independent valid/ready channels.
module memory_writer
    import memory_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned D = 256,
    localparam int unsigned A = $clog2(D)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*A:0]   cmd,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [W-1:0]   data,
    input  logic           data_valid,
    output logic           data_ready,
    output logic [A-1:0]   waddr,
    output logic           waddr_valid,
    input  logic           waddr_ready,
    output logic [W-1:0]   wdata,
    output logic           wdata_valid,
    input  logic           wdata_ready,
    output logic           done
);

    localparam logic [A-1:0] LastAddr = A'(D - 1);

    state_e       state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic [A:0]   rem_q, rem_d;
    logic         waddr_valid_q, waddr_valid_d;
    logic         wdata_valid_q, wdata_valid_d;
    logic [A-1:0] waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;

    logic [A-1:0] cmd_base;
    logic [A:0]   cmd_count;
    logic         waddr_free, wdata_free;

    assign cmd_base   = cmd[2*A:A+1];
    assign cmd_count  = cmd[A:0];
    // A channel is free if empty or draining on this edge.
    assign waddr_free = !waddr_valid_q || waddr_ready;
    assign wdata_free = !wdata_valid_q || wdata_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        waddr_valid_d = waddr_valid_q && !waddr_ready;
        wdata_valid_d = wdata_valid_q && !wdata_ready;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        cmd_ready     = 1'b0;
        data_ready    = 1'b0;
        done          = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        addr_d  = cmd_base;
                        rem_d   = cmd_count;
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                data_ready = (rem_q != '0) && waddr_free && wdata_free;
                if (data_ready && data_valid) begin
                    waddr_valid_d = 1'b1;
                    wdata_valid_d = 1'b1;
                    waddr_d       = addr_q;
                    wdata_d       = data;
                    addr_d        = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                    rem_d         = rem_q - 1'b1;
                end else if (rem_q == '0 && waddr_free && wdata_free) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            rem_q         <= '0;
            waddr_valid_q <= 1'b0;
            wdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            waddr_valid_q <= waddr_valid_d;
            wdata_valid_q <= wdata_valid_d;
        end
    end

    // Payload registers are qualified by their valids and carry no reset.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
    end

    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign waddr_valid = waddr_valid_q;
    assign wdata_valid = wdata_valid_q;

endmodule

// File: tb/tb_memory_writer.sv
// Randomized bench for memory_writer: expected address/data streams are built
// from the command (base + k mod D) and compared with observed transfers.
module tb_memory_writer;
    import memory_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned D     = 256;
    localparam int unsigned A     = $clog2(D);
    localparam int unsigned CW    = 2 * A + 1;
    localparam int          BOUND = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cmd;
    logic          cmd_valid, cmd_ready;
    logic [W-1:0]  data;
    logic          data_valid, data_ready;
    logic [A-1:0]  waddr;
    logic          waddr_valid, waddr_ready;
    logic [W-1:0]  wdata;
    logic          wdata_valid, wdata_ready;
    logic          done;

    memory_writer #(.W(W), .D(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .waddr       (waddr),
        .waddr_valid (waddr_valid),
        .waddr_ready (waddr_ready),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pw      = 100;
    int pd      = 100;

    logic [A-1:0] exp_addr[$];
    logic [A-1:0] got_addr[$];
    logic [W-1:0] exp_data[$];
    logic [W-1:0] got_data[$];
    logic [W-1:0] tbmem[D];
    int           wr_cnt[D];

    int fed, done_cnt, cmd_xfers, last_cmd_cyc, valids_seen, dr_viol, stab_viol;
    logic         p_ok = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_dv = 1'b0, p_dr = 1'b0;
    logic [A-1:0] p_wa;
    logic [W-1:0] p_wd;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        waddr_ready = ($urandom_range(99) < pw);
        wdata_ready = ($urandom_range(99) < pd);
    end

    // Observe all handshakes midway between active edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (waddr_valid && waddr_ready) got_addr.push_back(waddr);
            if (wdata_valid && wdata_ready) got_data.push_back(wdata);
            if (waddr_valid || wdata_valid) valids_seen++;
            if (data_ready && ((waddr_valid && !waddr_ready) || (wdata_valid && !wdata_ready)))
                dr_viol++;
            if (done) done_cnt++;
            if (cmd_valid && cmd_ready) begin
                cmd_xfers++;
                last_cmd_cyc = cyc;
            end
            if (p_ok && p_wv && !p_wr && (!waddr_valid || waddr != p_wa)) stab_viol++;
            if (p_ok && p_dv && !p_dr && (!wdata_valid || wdata != p_wd)) stab_viol++;
        end
        p_ok = !rst;
        p_wv = waddr_valid;
        p_wr = waddr_ready;
        p_wa = waddr;
        p_dv = wdata_valid;
        p_dr = wdata_ready;
        p_wd = wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep(int base, int count);
        exp_addr.delete();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
        fed         = 0;
        valids_seen = 0;
        dr_viol     = 0;
        stab_viol   = 0;
        for (int k = 0; k < count; k++) begin
            exp_addr.push_back(A'((base + k) % D));
            exp_data.push_back(W'($urandom));
        end
    endtask

    task automatic send_cmd(int base, int count);
        int n = 0;
        cmd       = CW'(pack_cmd(A, 32'(base), 32'(count)));
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < BOUND);
        check("cmd_accept", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic feed(int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            data       = exp_data[fed];
            data_valid = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!data_ready && t < BOUND);
            if (!data_ready) begin
                check("data_timeout", 0, 1);
                data_valid = 1'b0;
                return;
            end
            fed++;
            tick();
        end
        data_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < BOUND);
        check("done_seen", 32'(done), 1);
        dc = cyc;
    endtask

    task automatic finish(string tag, output int dc);
        int d0, errs;
        d0 = done_cnt;
        wait_done(dc);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        check({tag, "_n_addr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        check({tag, "_n_data"}, 32'(got_data.size()), 32'(exp_data.size()));
        errs = 0;
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (k >= got_addr.size() || got_addr[k] !== exp_addr[k]) errs++;
            if (k >= got_data.size() || got_data[k] !== exp_data[k]) errs++;
        end
        check({tag, "_pair_errs"}, 32'(errs), 0);
        check({tag, "_ready_viol"}, 32'(dr_viol), 0);
        check({tag, "_stable_viol"}, 32'(stab_viol), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, d0, x0, errs;
        rst        = 1'b1;
        cmd        = '0;
        cmd_valid  = 1'b0;
        data       = '0;
        data_valid = 1'b0;
        done_cnt   = 0;
        cmd_xfers  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_data_ready", 32'(data_ready), 0);
        check("rst_waddr_valid", 32'(waddr_valid), 0);
        check("rst_wdata_valid", 32'(wdata_valid), 0);
        check("rst_done", 32'(done), 0);
        tick();
        rst = 1'b0;
        tick();

        // Full sweep at full throughput, then readback through a model memory.
        prep(0, 256);
        send_cmd(0, 256);
        feed(256);
        finish("sweep", dc);
        check("sweep_cycles", 32'((dc - last_cmd_cyc >= 257) && (dc - last_cmd_cyc <= 259)), 1);
        for (int a = 0; a < D; a++) wr_cnt[a] = 0;
        for (int k = 0; k < got_addr.size() && k < got_data.size(); k++) begin
            tbmem[got_addr[k]] = got_data[k];
            wr_cnt[got_addr[k]]++;
        end
        errs = 0;
        for (int a = 0; a < D; a++)
            if (wr_cnt[a] != 1 || tbmem[a] !== exp_data[a]) errs++;
        check("sweep_readback_errs", 32'(errs), 0);
        tick();

        prep(250, 10);
        send_cmd(250, 10);
        feed(10);
        finish("wrap", dc);
        tick();

        pw = 50;
        pd = 30;
        begin
            int b = int'($urandom_range(D - 1));
            prep(b, 64);
            send_cmd(b, 64);
        end
        feed(64);
        finish("skew", dc);
        pw = 100;
        pd = 100;
        tick();

        prep(5, 0);
        d0 = done_cnt;
        send_cmd(5, 0);
        wait_done(dc);
        check("zero_done_lat", 32'(dc - last_cmd_cyc), 1);
        @(negedge clk);
        check("zero_cmd_ready_after", 32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        check("zero_no_valids", 32'(valids_seen), 0);
        check("zero_done_once", 32'(done_cnt - d0), 1);
        tick();

        // Abandon a command mid-run with reset.
        prep(20, 8);
        send_cmd(20, 8);
        feed(3);
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_waddr_valid", 32'(waddr_valid), 0);
        check("mrst_wdata_valid", 32'(wdata_valid), 0);
        check("mrst_data_ready", 32'(data_ready), 0);
        check("mrst_cmd_ready", 32'(cmd_ready), 1);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("mrst_no_done", 32'(done_cnt - d0), 0);
        prep(100, 2);
        send_cmd(100, 2);
        feed(2);
        finish("mrst_next", dc);
        tick();

        // Second command held during a run is taken only after done.
        prep(30, 5);
        send_cmd(30, 5);
        x0        = cmd_xfers;
        cmd       = CW'(pack_cmd(A, 32'd40, 32'd3));
        cmd_valid = 1'b1;
        feed(5);
        finish("bp_first", dc);
        tick();
        cmd_valid = 1'b0;
        check("bp_one_accept", 32'(cmd_xfers - x0), 1);
        check("bp_accept_cyc", 32'(last_cmd_cyc - dc), 1);
        prep(40, 3);
        feed(3);
        finish("bp_second", dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
